spi_ram_master: RTL and testbench

//  SPI initiator that drives the SPI slave + RAM subsystem from a parallel command port.
//  - Accepts one RAM command per valid/ready handshake and serializes it onto SS_n/SCLK/MOSI.
//  - For read-data commands, collects the RAM byte from MISO and returns it on rd_data/rd_valid.
//  - Sits in the host/test side of the design, opposite the SPI slave wrapper.

---
 rtl/spi_ram_master_pkg.sv | 23 ++
 rtl/spi_ram_master_if.sv | 24 ++
 rtl/spi_ram_master_sclk_gen.sv | 46 ++++
 rtl/spi_ram_master.sv | 171 +++++++++++++++++
 tb/tb_spi_ram_master.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_master_pkg.sv
// Shared definitions for the SPI RAM master: command opcodes, FSM states and a counter-width helper.
package spi_ram_master_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } spi_state_e;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_ram_master_if.sv
// Parallel command/response port of the SPI RAM master.
interface spi_ram_master_if #(
  parameter int unsigned ADDR_SIZE = 8
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [ADDR_SIZE-1:0] cmd_payload;
  logic [ADDR_SIZE-1:0] rd_data;
  logic                 rd_valid;
  logic                 busy;

  modport master (
    output cmd_valid, cmd_op, cmd_payload,
    input  cmd_ready, rd_data, rd_valid, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_payload,
    output cmd_ready, rd_data, rd_valid, busy
  );

endinterface

// File: rtl/spi_ram_master_sclk_gen.sv
// SCLK divider: toggles every SCLK_DIV clk while enabled and flags the clk before each SCLK edge.
module spi_ram_master_sclk_gen
  import spi_ram_master_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic hold_low_i,
  output logic sclk_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o
);

  localparam int unsigned CW = cnt_w(SCLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCLK_DIV - 1);

  logic [CW-1:0] div_q;
  logic          phase_q;
  logic          tick;

  assign tick        = en_i && (div_q == DIV_LAST);
  assign sclk_rise_o = tick && !phase_q;
  assign sclk_fall_o = tick &&  phase_q;

  // hold_low_i keeps the half-period timing running while the pin stays low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      sclk_o  <= 1'b0;
    end else if (!en_i) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      sclk_o  <= 1'b0;
    end else if (tick) begin
      div_q   <= '0;
      phase_q <= !phase_q;
      sclk_o  <= !phase_q && !hold_low_i;
    end else begin
      div_q   <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_ram_master.sv
// SPI initiator: serializes one RAM command per handshake and returns the read byte for op 11.
module spi_ram_master
  import spi_ram_master_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned SCLK_DIV  = 2,
  parameter int unsigned RD_WAIT   = 2,
  parameter int unsigned IDLE_GAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  spi_ram_master_if.slave  cmd,
  output logic             SS_n,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int unsigned N_CMD    = ADDR_SIZE + 3;
  localparam int unsigned N_TOT    = N_CMD + RD_WAIT + ADDR_SIZE;
  localparam int unsigned BW       = cnt_w(N_TOT + 1);
  localparam int unsigned GAP_CLKS = IDLE_GAP * 2 * SCLK_DIV;
  localparam int unsigned GW       = cnt_w(GAP_CLKS);

  localparam logic [BW-1:0] LAST_CMD  = BW'(N_CMD - 1);
  localparam logic [BW-1:0] LAST_WAIT = BW'(N_CMD + RD_WAIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(N_TOT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);
  localparam spi_state_e    AFTER_CMD = (RD_WAIT == 0) ? ST_RECV : ST_WAIT;

  spi_state_e           state_q;
  logic [1:0]           op_q;
  logic [N_CMD-1:0]     sh_q;
  logic [BW-1:0]        bit_q;
  logic [GW-1:0]        gap_q;
  logic                 tail_q;
  logic [ADDR_SIZE-1:0] rx_q;
  logic                 ss_n_q;
  logic                 mosi_q;
  logic                 ready_q;
  logic                 busy_q;
  logic [ADDR_SIZE-1:0] rd_data_q;
  logic                 rd_valid_q;

  logic [N_CMD-1:0]     frame_w;
  logic                 sclk_en;
  logic                 sclk_rise;
  logic                 sclk_fall;

  assign frame_w = {cmd.cmd_op[1], cmd.cmd_op, cmd.cmd_payload};
  assign sclk_en = state_q inside {ST_SETUP, ST_SEND, ST_WAIT, ST_RECV};

  spi_ram_master_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (sclk_en),
    .hold_low_i  (tail_q),
    .sclk_o      (SCLK),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall)
  );

  // tail_q marks the trailing low half-period: the suppressed rise strobe closes the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      sh_q       <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      tail_q     <= 1'b0;
      rx_q       <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (cmd.cmd_valid && ready_q) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            op_q    <= cmd.cmd_op;
            mosi_q  <= frame_w[N_CMD-1];
            sh_q    <= {frame_w[N_CMD-2:0], 1'b0};
            ss_n_q  <= 1'b0;
            bit_q   <= '0;
            tail_q  <= 1'b0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (sclk_rise) state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (tail_q) begin
            if (sclk_rise) begin
              ss_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              tail_q  <= 1'b0;
              gap_q   <= '0;
              state_q <= ST_GAP;
            end
          end else if (sclk_fall) begin
            bit_q <= bit_q + 1'b1;
            if (bit_q == LAST_CMD) begin
              if (op_q == OP_RD_DATA) begin
                mosi_q  <= 1'b0;
                state_q <= AFTER_CMD;
              end else begin
                tail_q  <= 1'b1;
              end
            end else begin
              mosi_q <= sh_q[N_CMD-1];
              sh_q   <= {sh_q[N_CMD-2:0], 1'b0};
            end
          end
        end
        ST_WAIT: begin
          if (sclk_fall) begin
            bit_q <= bit_q + 1'b1;
            if (bit_q == LAST_WAIT) state_q <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (tail_q) begin
            if (sclk_rise) begin
              ss_n_q     <= 1'b1;
              mosi_q     <= 1'b0;
              tail_q     <= 1'b0;
              gap_q      <= '0;
              rd_data_q  <= rx_q;
              rd_valid_q <= 1'b1;
              state_q    <= ST_GAP;
            end
          end else begin
            if (sclk_rise) rx_q <= {rx_q[ADDR_SIZE-2:0], MISO};
            if (sclk_fall) begin
              bit_q <= bit_q + 1'b1;
              if (bit_q == LAST_BIT) tail_q <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          gap_q <= gap_q + 1'b1;
          if (gap_q == GAP_LAST) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign SS_n          = ss_n_q;
  assign MOSI          = mosi_q;
  assign cmd.cmd_ready = ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.rd_data   = rd_data_q;
  assign cmd.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master with a behavioural SPI slave + RAM model on the serial side.
module tb_spi_ram_master;
  import spi_ram_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SS_n, SCLK, MOSI;
  logic MISO = 1'b0;

  int vecs = 0;
  int errs = 0;

  spi_ram_master_if #(.ADDR_SIZE(8)) bus ();

  spi_ram_master #(
    .ADDR_SIZE (8),
    .SCLK_DIV  (2),
    .RD_WAIT   (2),
    .IDLE_GAP  (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (bus),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  // Slave + RAM model and frame monitors, all sampled on posedge clk.
  logic [7:0]  s_mem [256];
  logic [7:0]  s_addr = 8'h00;
  logic [1:0]  m_op = 2'b00;
  logic [9:0]  m_sh = '0;
  logic [10:0] m_vec = '0;
  logic        sclk_d1 = 1'b0;
  logic        ss_d1 = 1'b1;
  int m_rises = 0, m_falls = 0;
  int ss_low_cnt = 0, last_ss_low = 0, hi_cnt = 0, last_hi = 0;
  int rv_cnt = 0, rv_on_rise = 0, gap_cnt = 0, ready_in_frame = 0;

  always @(posedge clk) begin
    sclk_d1 <= SCLK;
    ss_d1   <= SS_n;
    if (bus.rd_valid) rv_cnt <= rv_cnt + 1;
    if (bus.rd_valid && SS_n && !ss_d1) rv_on_rise <= rv_on_rise + 1;
    if (!SS_n) begin
      ss_low_cnt <= ss_low_cnt + 1;
      gap_cnt    <= 0;
      if (bus.cmd_ready) ready_in_frame <= ready_in_frame + 1;
    end
    if (SS_n && !ss_d1) begin
      last_ss_low <= ss_low_cnt;
      ss_low_cnt  <= 0;
    end
    if (SS_n) hi_cnt <= hi_cnt + 1;
    if (!SS_n && ss_d1) begin
      last_hi <= hi_cnt;
      hi_cnt  <= 0;
    end
    if (SS_n && !bus.cmd_ready && bus.busy) gap_cnt <= gap_cnt + 1;

    if (SS_n) begin
      m_rises <= 0;
      m_falls <= 0;
      MISO    <= 1'b0;
    end else begin
      if (SCLK && !sclk_d1) begin
        if (m_rises < 11) begin
          m_sh           <= {m_sh[8:0], MOSI};
          m_vec[10-m_rises] <= MOSI;
        end
        if (m_rises == 10) begin
          m_op <= m_sh[8:7];
          case (m_sh[8:7])
            2'b00, 2'b10: s_addr <= {m_sh[6:0], MOSI};
            2'b01:        s_mem[s_addr] <= {m_sh[6:0], MOSI};
            default: ;
          endcase
        end
        m_rises <= m_rises + 1;
      end
      if (!SCLK && sclk_d1) begin
        m_falls <= m_falls + 1;
        if (m_op == 2'b11 && m_falls >= 12 && m_falls <= 19)
          MISO <= s_mem[s_addr][19-m_falls];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!bus.cmd_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(t < 400), 1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] pl);
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_payload = pl;
    wait_ready("accept_timeout");
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_ready("done_timeout");
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 2'b00;
    bus.cmd_payload = 8'h00;

    // Reset state
    #12;
    chk("rst_ss_n",   SS_n, 1);
    chk("rst_sclk",   SCLK, 0);
    chk("rst_mosi",   MOSI, 0);
    chk("rst_rvalid", bus.rd_valid, 0);
    chk("rst_ready",  bus.cmd_ready, 0);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_rdata",  bus.rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_before_edge", bus.cmd_ready, 0);
    @(negedge clk);
    chk("ready_first_edge", bus.cmd_ready, 1);
    chk("busy_idle", bus.busy, 0);

    // op 00, payload 3C
    issue(OP_WR_ADDR, 8'h3C);
    chk("wr_addr_mosi", m_vec, 11'b000_0011_1100);
    chk("wr_addr_ss_low", last_ss_low, 46);
    chk("wr_addr_no_rvalid", rv_cnt, 0);

    // op 01, payload A5
    issue(OP_WR_DATA, 8'hA5);
    chk("wr_data_mosi", m_vec, 11'b001_1010_0101);
    chk("wr_data_ss_low", last_ss_low, 46);
    chk("ready_gap_after_ss", gap_cnt, 4);
    chk("ready_inside_frame", ready_in_frame, 0);

    // op 11 returning 5A
    issue(OP_WR_ADDR, 8'h44);
    issue(OP_WR_DATA, 8'h5A);
    issue(OP_RD_ADDR, 8'h44);
    chk("rd_addr_no_rvalid", rv_cnt, 0);
    chk("rd_addr_ss_low", last_ss_low, 46);
    issue(OP_RD_DATA, 8'h00);
    chk("rd_data_value", bus.rd_data, 8'h5A);
    chk("rd_data_ss_low", last_ss_low, 86);
    chk("rd_data_one_rvalid", rv_cnt, 1);
    chk("rd_data_rvalid_at_ss_rise", rv_on_rise, 1);
    chk("rd_data_rvalid_low_after", bus.rd_valid, 0);
    chk("rd_data_mosi", m_vec, 11'b111_0000_0000);

    // cmd_valid held across op 10 then op 11, inputs changed mid-frame
    issue(OP_WR_ADDR, 8'h20);
    issue(OP_WR_DATA, 8'h96);
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = OP_RD_ADDR;
    bus.cmd_payload = 8'h20;
    wait_ready("held1_timeout");
    @(negedge clk);
    bus.cmd_op      = OP_RD_DATA;
    bus.cmd_payload = 8'h0F;
    wait_ready("held2_timeout");
    @(negedge clk);
    bus.cmd_op      = OP_WR_ADDR;
    bus.cmd_payload = 8'hF0;
    repeat (10) @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_ready("held_done_timeout");
    chk("held_rd_value", bus.rd_data, 8'h96);
    chk("held_one_rvalid", rv_cnt, 2);
    chk("held_rvalid_at_ss_rise", rv_on_rise, 2);
    chk("held_gap_ge4", 32'(last_hi >= 4), 1);
    chk("held_frame2_mosi", m_vec, 11'b111_0000_1111);
    chk("held_slave_addr", s_addr, 8'h20);
    chk("held_frame2_ss_low", last_ss_low, 86);
    repeat (20) @(negedge clk);
    chk("held_no_third_frame", SS_n, 1);

    // Reset in the middle of an op 11 frame
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_RD_DATA;
    wait_ready("abort_accept_timeout");
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_in_frame", SS_n, 0);
    #1 rst = 1'b1;
    #1;
    chk("abort_ss_n",   SS_n, 1);
    chk("abort_sclk",   SCLK, 0);
    chk("abort_mosi",   MOSI, 0);
    chk("abort_rvalid", bus.rd_valid, 0);
    chk("abort_rdata",  bus.rd_data, 0);
    chk("abort_ready",  bus.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_ready_before_edge", bus.cmd_ready, 0);
    @(negedge clk);
    chk("abort_ready_first_edge", bus.cmd_ready, 1);
    chk("abort_no_rvalid", rv_cnt, 2);

    // End to end through the slave + RAM model
    issue(OP_WR_ADDR, 8'h10);
    issue(OP_WR_DATA, 8'hC3);
    issue(OP_RD_ADDR, 8'h10);
    issue(OP_RD_DATA, 8'h55);
    chk("e2e_rd_value", bus.rd_data, 8'hC3);
    chk("e2e_rvalid_count", rv_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
